traveler_cmd_encoder: RTL
=========================

# traveler_cmd_encoder

Parametrised successor to the traveler button front end. It samples `NUM_BTN` raw push-buttons in the `uart_clk` domain, synchronises and debounces them as a vector, and turns each accepted single-button press into one operation byte. Bytes are buffered in a small command FIFO and offered to the UART transmitter over a valid/ready handshake. Every press is therefore sent exactly once, instead of the operation level being held.

## Interface
- `NUM_BTN`, default 5: number of buttons; legal range 1..6.
- `DEBOUNCE_CNT`, default 15000: consecutive stable cycles required to accept a new vector; must be ≥ 2.
- `CNT_W`, default 21: debounce counter width; must satisfy `DEBOUNCE_CNT < 2**CNT_W`.
- `FIFO_DEPTH`, default 4: command FIFO entries; power of two, ≥ 2.
- `REPEAT_CNT`, default 150000: auto-repeat period in cycles; used only with `AUTO_REPEAT_EN`.
- `uart_clk` in 1: sole clock.
- `rst` in 1: synchronous, active-high reset.
- `btn` in NUM_BTN: raw asynchronous buttons; bit i = operation i.
- `tx_ready` in 1: UART transmitter can accept a byte this cycle.
- `tx_valid` out 1: FIFO non-empty; `tx_data` is valid.
- `tx_data` out 8: FIFO head, or the IGNORE byte when empty.
- `stable_btn` out NUM_BTN: debounced button vector.
- `dropped` out 1: one-cycle pulse when a command is lost because the FIFO is full.

## Operation
- Byte format: `{1'b0, onehot[4:0] zero-extended/placed at bits [6:2], 2'b10}`.
  - Bits [7:2] carry `1 << i` for button i.
  - Bits [1:0] are always `2'b10`.
  - Examples: button 0 = 8'h06, button 4 = 8'h42, IGNORE = 8'h02.
- Synchroniser: `btn` passes through two flops; the second flop output is the sampled vector `s`.
- Debounce (vector-wide):
  - If `s != cand`: `cand <= s`, `cnt <= 0`.
  - Else if `cnt == DEBOUNCE_CNT-1`: `cnt <= DEBOUNCE_CNT` (saturate) and `stable_btn <= cand`.
  - Else if `cnt < DEBOUNCE_CNT`: `cnt <= cnt+1`.
  - Any bounce restarts the count.
- Press detection, evaluated on the edge that updates `stable_btn`: if the new stable vector is exactly one-hot and differs from the old one, enqueue its byte.
  - Releases (to zero) enqueue nothing.
  - Multi-button vectors enqueue nothing.
  - A direct one-hot to different one-hot transition enqueues the new button.
- FIFO: show-ahead.
  - `tx_valid = (count != 0)`; `tx_data` = head entry.
  - Pop when `tx_valid & tx_ready`.
  - Push when full with no pop in the same cycle: drop the command and pulse `dropped`.
  - Push and pop in the same cycle while full: both occur, no drop.
  - `tx_ready` while empty: ignored.
- Pointers wrap modulo `FIFO_DEPTH`. Count width is log2(FIFO_DEPTH)+1, so full and empty are distinguishable.

## Timing
- Reset values:
  - `tx_valid` = 0, `tx_data` = 8'h02, `stable_btn` = 0, `dropped` = 0.
  - Internally: synchroniser flops, `cand` and `cnt` = 0; FIFO emptied.
- Reset asserted mid-operation discards all queued commands and any in-progress debounce on the next edge.
- Latency: a level first captured at edge E0 and held steady updates `stable_btn` at edge E0+DEBOUNCE_CNT+2. `tx_valid` rises at that same edge if the FIFO was empty.
- A byte stays on `tx_data` with `tx_valid` high until the cycle `tx_ready` is high; the next entry appears after that edge.
- `dropped` is registered and high for exactly one cycle per lost command.

## Configuration
- `AUTO_REPEAT_EN` defined:
  - Adds a repeat counter, cleared on every `stable_btn` update.
  - While `stable_btn` stays one-hot, the counter re-enqueues the same byte every `REPEAT_CNT` cycles, subject to the normal full/drop rules.
  - The counter wraps to 0 after each repeat.
- `AUTO_REPEAT_EN` undefined: no repeat logic; exactly one command per accepted press.

## Test plan
- DEBOUNCE_CNT=4: reset, hold `btn`=5'b00001 steady → `stable_btn`=00001 and `tx_valid`=1 with `tx_data`=8'h06 at E0+6. Hold `tx_ready`=1 one cycle → `tx_valid`=0, `tx_data`=8'h02.
- Toggle `btn` bit 4 every 3 cycles for 30 cycles, then hold 1 → no enqueue during bouncing; exactly one 8'h42 after the level is held for 4+2 edges.
- Press 00011 (two buttons), release, then press 00100 → only 8'h12 is queued; `stable_btn` reports 00011 during the double press.
- `tx_ready`=0, FIFO_DEPTH=4: issue 5 distinct presses → 4 bytes queued in order, `dropped` pulses once on the 5th. Then full with push and pop in the same cycle → no drop.
- Assert `rst` for 1 cycle while 3 bytes are queued and a debounce is half complete → next cycle `tx_valid`=0, `stable_btn`=0; a steady button re-debounces from count 0.
- With `AUTO_REPEAT_EN`, REPEAT_CNT=10: hold button 2 for 40 cycles past acceptance → 8'h12 queued 1 + 4 times at 10-cycle spacing. Without the macro → exactly 1.

Source files
------------

// File: rtl/traveler_cmd_encoder.sv
// Button front end: synchronise, debounce and encode single-button presses into a show-ahead command FIFO.
// Optional feature macro: AUTO_REPEAT_EN (re-enqueue a held button every REPEAT_CNT cycles).
module traveler_cmd_encoder #(
    parameter int NUM_BTN      = 5,
    parameter int DEBOUNCE_CNT = 15000,
    parameter int CNT_W        = 21,
    parameter int FIFO_DEPTH   = 4,
    parameter int REPEAT_CNT   = 150000
) (
    input  logic               uart_clk,
    input  logic               rst,
    input  logic [NUM_BTN-1:0] btn,
    input  logic               tx_ready,
    output logic               tx_valid,
    output logic [7:0]         tx_data,
    output logic [NUM_BTN-1:0] stable_btn,
    output logic               dropped
);

    localparam int         AW          = $clog2(FIFO_DEPTH);
    localparam logic [7:0] IGNORE_BYTE = 8'h02;

    function automatic logic is_onehot(input logic [NUM_BTN-1:0] v);
        return (v != '0) && ((v & (v - NUM_BTN'(1))) == '0);
    endfunction

    function automatic logic [7:0] encode(input logic [NUM_BTN-1:0] v);
        logic [5:0] field;
        field = '0;
        field[NUM_BTN-1:0] = v;
        return {field, 2'b10};
    endfunction

    logic [NUM_BTN-1:0] sync_p0, sync_p1;
    logic [NUM_BTN-1:0] cand;
    logic [CNT_W-1:0]   cnt;
    logic               upd;
    logic               press_push;
    logic               push;
    logic [7:0]         push_byte;

    // Stage p0/p1: two-flop synchroniser
    always_ff @(posedge uart_clk) begin
        if (rst) begin
            sync_p0 <= '0;
            sync_p1 <= '0;
        end else begin
            sync_p0 <= btn;
            sync_p1 <= sync_p0;
        end
    end

    // Debounce: any change of the sampled vector restarts the count
    assign upd = (sync_p1 == cand) && (cnt == CNT_W'(DEBOUNCE_CNT - 1));

    always_ff @(posedge uart_clk) begin
        if (rst) begin
            cand       <= '0;
            cnt        <= '0;
            stable_btn <= '0;
        end else if (sync_p1 != cand) begin
            cand <= sync_p1;
            cnt  <= '0;
        end else if (upd) begin
            cnt        <= CNT_W'(DEBOUNCE_CNT);
            stable_btn <= cand;
        end else if (cnt < CNT_W'(DEBOUNCE_CNT)) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign press_push = upd && is_onehot(cand) && (cand != stable_btn);

`ifdef AUTO_REPEAT_EN
    localparam int RPT_W = $clog2(REPEAT_CNT + 1);

    logic [RPT_W-1:0] rpt_cnt;
    logic             rpt_push;

    assign rpt_push = !upd && is_onehot(stable_btn) && (rpt_cnt == RPT_W'(REPEAT_CNT - 1));

    always_ff @(posedge uart_clk) begin
        if (rst || upd) begin
            rpt_cnt <= '0;
        end else if (is_onehot(stable_btn)) begin
            rpt_cnt <= rpt_push ? '0 : rpt_cnt + RPT_W'(1);
        end else begin
            rpt_cnt <= '0;
        end
    end

    assign push      = press_push | rpt_push;
    assign push_byte = press_push ? encode(cand) : encode(stable_btn);
`else
    logic unused_repeat_cfg;
    assign unused_repeat_cfg = (REPEAT_CNT != 0);
    assign push      = press_push;
    assign push_byte = encode(cand);
`endif

    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    logic          full, pop, push_ok;

    assign full     = (count == (AW + 1)'(FIFO_DEPTH));
    assign pop      = tx_valid && tx_ready;
    assign push_ok  = push && (!full || pop);
    assign tx_valid = (count != '0);
    assign tx_data  = tx_valid ? mem[rd_ptr] : IGNORE_BYTE;

    // Command FIFO: a full push only survives if the head leaves in the same cycle
    always_ff @(posedge uart_clk) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            dropped <= 1'b0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + AW'(1);
            if (pop)     rd_ptr <= rd_ptr + AW'(1);
            unique case ({push_ok, pop})
                2'b10:   count <= count + (AW + 1)'(1);
                2'b01:   count <= count - (AW + 1)'(1);
                default: count <= count;
            endcase
            dropped <= push && full && !pop;
        end
    end

    always_ff @(posedge uart_clk) begin
        if (push_ok && !rst) mem[wr_ptr] <= push_byte;
    end

endmodule
